// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment patterns and glyph codes for the seven-segment mux.
// Glyph codes are 5 bits: 0x00-0x0F are the hex digits, then two extra glyphs
// for the error display ("r") and an all-off blank.
package seven_segment_pkg;

    // Segment patterns, {a,b,c,d,e,f,g} with a in bit 6, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_R     = 7'b0000101;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Glyph codes fed to the decoder.
    localparam int         CODE_W     = 5;
    localparam logic [4:0] CODE_E     = 5'h0E;
    localparam logic [4:0] CODE_R     = 5'h10;
    localparam logic [4:0] CODE_BLANK = 5'h11;

    // Hex nibble to glyph code.
    function automatic logic [4:0] hex_code(input logic [3:0] nibble);
        return {1'b0, nibble};
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: purely combinational glyph-code to segment-pattern
// lookup. The caller registers the result.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        pattern
);

    // Glyph lookup; unknown codes (including CODE_BLANK) turn all segments off.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
        pattern = SEG_BLANK;
        case (code)
            5'h00:   pattern = SEG_0;
            5'h01:   pattern = SEG_1;
            5'h02:   pattern = SEG_2;
            5'h03:   pattern = SEG_3;
            5'h04:   pattern = SEG_4;
            5'h05:   pattern = SEG_5;
            5'h06:   pattern = SEG_6;
            5'h07:   pattern = SEG_7;
            5'h08:   pattern = SEG_8;
            5'h09:   pattern = SEG_9;
            5'h0A:   pattern = SEG_A;
            5'h0B:   pattern = SEG_B;
            5'h0C:   pattern = SEG_C;
            5'h0D:   pattern = SEG_D;
            5'h0E:   pattern = SEG_E;
            5'h0F:   pattern = SEG_F;
            CODE_R:  pattern = SEG_R;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_mux.sv
// seven_segment_mux: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits. A prescaler divides clk into digit slots; the digit
// index scans from the leftmost digit down to digit 0. Inputs are captured
// once per frame so a frame never mixes old and new data.
// Optional feature: define SEVEN_SEGMENT_MUX_BRIGHTNESS_EN to PWM the active
// digit's enable inside each slot according to 'brightness'.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 65536,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [3:0]              error,
    input  logic [BRIGHT_WIDTH-1:0] brightness,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int                CNT_W     = $clog2(REFRESH_DIV);
    localparam int                IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    slot_tick;
    logic                    frame_start;
    logic                    running;

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [3:0]              snap_error;

    logic [CODE_W-1:0]       glyph_code;
    logic [6:0]              glyph_seg;
    logic                    digit_on;
    logic [NUM_DIGITS-1:0]   an_next;

    assign slot_tick   = (cnt == CNT_LAST);
    assign frame_start = slot_tick && (idx == '0);

    // Prescaler and digit index: one index step per slot, wrapping to the leftmost digit.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            cnt <= '0;
            idx <= IDX_FIRST;
        end else begin
            cnt <= slot_tick ? '0 : cnt + 1'b1;
            if (slot_tick) begin
                idx <= (idx == '0) ? IDX_FIRST : idx - 1'b1;
            end
        end
    end

    // Frame snapshot: all displayed data comes from here, refreshed only at frame start.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the snapshot is plain flops, not a memory array, so it is reset and the pre-first-frame display is defined (zeros).
        if (rst) begin
            snap_digits <= '0;
            snap_blank  <= '0;
            snap_error  <= '0;
        end else if (frame_start) begin
            snap_digits <= digits;
            snap_blank  <= blank;
            snap_error  <= error;
        end
    end

    // Glyph selection for the current digit: error pattern E r..r <code>, else nibble or blank.
    always_comb begin
        glyph_code = CODE_BLANK;
        if (snap_error != 4'h0) begin
            if (idx == IDX_FIRST) begin
                glyph_code = CODE_E;
            end else if (idx == '0) begin
                glyph_code = hex_code(snap_error);
            end else begin
                glyph_code = CODE_R;
            end
        end else if (!snap_blank[idx]) begin
            glyph_code = hex_code(snap_digits[{idx, 2'b00} +: 4]);
        end
    end

    seven_segment_decoder u_decoder (
        .code    (glyph_code),
        .pattern (glyph_seg)
    );

`ifdef SEVEN_SEGMENT_MUX_BRIGHTNESS_EN
    // Each slot splits into 2**BRIGHT_WIDTH sub-slots; the digit is lit for the
    // first 'brightness' of them, and all-ones means lit for the whole slot.
    localparam int SUB_DIV = REFRESH_DIV >> BRIGHT_WIDTH;

    logic [CNT_W-1:0] sub;

    assign sub      = cnt / CNT_W'(SUB_DIV);
    assign digit_on = (brightness == '1) || (sub < CNT_W'(brightness));
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign digit_on          = 1'b1;
`endif

    // Active-low one-hot enable for the current digit, or all off.
    always_comb begin
        an_next = '1;
        if (digit_on) begin
            an_next[idx] = 1'b0;
        end
    end

    // Output registers; 'running' holds them off for the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            seg     <= SEG_BLANK;
            an      <= '1;
        end else begin
            running <= 1'b1;
            if (running) begin
                seg <= glyph_seg;
                an  <= an_next;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
// tb_seven_segment_mux: directed self-checking bench for seven_segment_mux with
// NUM_DIGITS=4, REFRESH_DIV=16, BRIGHT_WIDTH=4. Brightness checks follow
// whether SEVEN_SEGMENT_MUX_BRIGHTNESS_EN is defined for the build.
module tb_seven_segment_mux;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] GB = 7'b0011111;
    localparam logic [6:0] GC = 7'b1001110;
    localparam logic [6:0] GD = 7'b0111101;
    localparam logic [6:0] GE = 7'b1001111;
    localparam logic [6:0] GR = 7'b0000101;
    localparam logic [6:0] GX = 7'b0000000;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  error;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;

    seven_segment_mux #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (16),
        .BRIGHT_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .blank      (blank),
        .error      (error),
        .brightness (brightness),
        .seg        (seg),
        .an         (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] an_mask(input int d);
        logic [3:0] m;
        m    = 4'hF;
        m[d] = 1'b0;
        return m;
    endfunction

    // Full 16-cycle slot with digit d lit and the given glyph.
    task automatic check_slot(input string tag, input int d, input logic [6:0] exp_seg);
        for (int c = 0; c < 16; c++) begin
            check({tag, "_an"}, 32'(an), 32'(an_mask(d)));
            check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
            step(1);
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] g3, input logic [6:0] g2,
                               input logic [6:0] g1, input logic [6:0] g0);
        check_slot({tag, "_d3"}, 3, g3);
        check_slot({tag, "_d2"}, 2, g2);
        check_slot({tag, "_d1"}, 1, g1);
        check_slot({tag, "_d0"}, 0, g0);
    endtask

    // Count cycles in a slot where digit d is enabled; any other an value but all-off is illegal.
    task automatic meas_slot(input string tag, input int d, input logic [6:0] exp_seg, input int exp_low);
        int low;
        int bad;
        low = 0;
        bad = 0;
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
        for (int c = 0; c < 16; c++) begin
            if (an == an_mask(d)) low++;
            else if (an != 4'hF) bad++;
            step(1);
        end
        check({tag, "_low"}, 32'(low), 32'(exp_low));
        check({tag, "_illegal"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int exp_b4;
        int exp_b15;
        int exp_b0;
`ifdef SEVEN_SEGMENT_MUX_BRIGHTNESS_EN
        exp_b4  = 4;
        exp_b15 = 16;
        exp_b0  = 0;
`else
        exp_b4  = 16;
        exp_b15 = 16;
        exp_b0  = 16;
`endif
        rst        = 1'b1;
        digits     = 16'h1234;
        blank      = 4'b0000;
        error      = 4'h0;
        brightness = 4'hF;

        repeat (3) @(negedge clk);
        check("reset_seg", 32'(seg), 32'(GX));
        check("reset_an", 32'(an), 32'hF);
        rst = 1'b0;

        // First edge after release keeps digits off, second lights digit 3 with the zero snapshot.
        step(1);
        check("rel_edge1_an", 32'(an), 32'hF);
        step(1);
        check("rel_edge2_an", 32'(an), 32'b0111);
        check("rel_edge2_seg", 32'(seg), 32'(G0));

        // First frame start captures 0x1234; its first digit appears at edge 65.
        step(63);
        check_frame("f1234", G1, G2, G3, G4);

        // Mid-frame change must not tear the current frame.
        check_slot("mid_d3", 3, G1);
        check_slot("mid_d2", 2, G2);
        digits = 16'hABCD;
        check_slot("mid_d1", 1, G3);
        check_slot("mid_d0", 0, G4);

        check_slot("fabcd_d3", 3, GA);
        error = 4'h7;
        check_slot("fabcd_d2", 2, GB);
        check_slot("fabcd_d1", 1, GC);
        check_slot("fabcd_d0", 0, GD);

        check_slot("err7_d3", 3, GE);
        error = 4'h0;
        check_slot("err7_d2", 2, GR);
        check_slot("err7_d1", 1, GR);
        check_slot("err7_d0", 0, G7);

        check_slot("restore_d3", 3, GA);
        blank  = 4'b0101;
        digits = 16'h8888;
        check_slot("restore_d2", 2, GB);
        check_slot("restore_d1", 1, GC);
        check_slot("restore_d0", 0, GD);

        check_slot("blank_d3", 3, G8);
        error = 4'hC;
        check_slot("blank_d2", 2, GX);
        check_slot("blank_d1", 1, G8);
        check_slot("blank_d0", 0, GX);

        // Error mode ignores blank bits, digit 0 shows the error nibble.
        check_slot("errc_d3", 3, GE);
        error  = 4'h0;
        blank  = 4'b0000;
        digits = 16'h1234;
        check_slot("errc_d2", 2, GR);
        check_slot("errc_d1", 1, GR);
        check_slot("errc_d0", 0, GC);

        // Brightness: change it, let one slot pass, then measure.
        check_slot("pre_b_d3", 3, G1);
        brightness = 4'd4;
        step(16);
        meas_slot("b4_d1", 1, G3, exp_b4);
        meas_slot("b4_d0", 0, G4, exp_b4);
        brightness = 4'd15;
        step(16);
        meas_slot("b15_d2", 2, G2, exp_b15);
        meas_slot("b15_d1", 1, G3, exp_b15);
        meas_slot("b15_d0", 0, G4, exp_b15);
        brightness = 4'd0;
        step(16);
        meas_slot("b0_d2", 2, G2, exp_b0);
        meas_slot("b0_d1", 1, G3, exp_b0);
        meas_slot("b0_d0", 0, G4, exp_b0);
        brightness = 4'hF;
        step(16);

        // Asynchronous reset mid-slot, checked before any clock edge.
        step(5);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_seg", 32'(seg), 32'(GX));
        check("async_rst_an", 32'(an), 32'hF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1);
        check("rerel_edge1_an", 32'(an), 32'hF);
        step(1);
        check("rerel_edge2_an", 32'(an), 32'b0111);
        check("rerel_edge2_seg", 32'(seg), 32'(G0));
        step(15);
        check("rerel_next_an", 32'(an), 32'b1011);
        check("rerel_next_seg", 32'(seg), 32'(G0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_mux.md
SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 65536: clk cycles per digit slot; a multiple of 2**BRIGHT_WIDTH, at least 16.
REQ-003 Parameter BRIGHT_WIDTH, default 4: width of the brightness control.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 digits  in  4*NUM_DIGITS  hex nibble per digit; nibble i drives digit i, digit 0 is rightmost.
REQ-007 blank  in  NUM_DIGITS  bit i set blanks digit i (all segments off).
REQ-008 error  in  4  nonzero selects error display.
REQ-009 brightness  in  BRIGHT_WIDTH  duty control.
REQ-010 seg  out  7  segments {a,b,c,d,e,f,g}, a in bit 6, active-high.
REQ-011 an  out  NUM_DIGITS  digit enables, active-low, at most one low at any time.

Function
REQ-012 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; the wrap cycle is the slot tick.
REQ-013 The digit index SHALL scan NUM_DIGITS-1 down to 0, then wrap to NUM_DIGITS-1, advancing one step per slot tick.
REQ-014 The frame start is the slot tick on which the index wraps to NUM_DIGITS-1; at that tick digits, blank and error SHALL be captured into a frame snapshot.
REQ-015 All displayed data SHALL come from the snapshot, so input changes appear only at the next frame start (no tearing).
REQ-016 seg and an SHALL be registered and reflect the current index and snapshot one cycle after the index changes.
REQ-017 Glyphs SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111, r=0000101, blank=0000000.
REQ-018 In normal mode, digit i SHALL show its nibble's glyph, or blank if its blank bit is set.
REQ-019 In error mode (snapshot error nonzero), digit NUM_DIGITS-1 SHALL show E, digit 0 the hex glyph of error, and all others r; blank bits are ignored.
REQ-020 A change to error mid-frame SHALL take effect only at the next frame start.

Reset
REQ-021 While rst is high: prescaler 0, index NUM_DIGITS-1, snapshot all zero, seg 0000000, an all ones.
REQ-022 After rst deasserts, the first digit SHALL be enabled on the second rising edge, showing the zero snapshot until the first frame start.
REQ-023 rst asserted mid-slot SHALL force the reset values immediately, without waiting for a clock edge.

Configuration
REQ-024 With SEVEN_SEGMENT_MUX_BRIGHTNESS_EN defined, let sub = prescaler / (REFRESH_DIV >> BRIGHT_WIDTH); the active digit's an bit SHALL be low only while sub < brightness, and all-ones brightness SHALL give 100% duty.
REQ-025 Without the macro, brightness SHALL be ignored and the active digit enabled for the whole slot.
REQ-026 brightness 0 with the macro defined SHALL keep an all ones; the scan SHALL continue.

Structure
REQ-027 Package seven_segment_pkg SHALL hold the glyph constants and the error-glyph nibble codes.
REQ-028 Sub-module seven_segment_decoder SHALL convert a 5-bit glyph code to a 7-bit pattern; it is purely combinational and its output is registered in seven_segment_mux.

Verification (NUM_DIGITS=4, REFRESH_DIV=16, BRIGHT_WIDTH=4)
REQ-029 Reset release, digits=0x1234 held -> after the first frame start, an cycles 0111,1011,1101,1110 with seg 0110000,1101101,1111001,0110011 (each 16 cycles).
REQ-030 Change digits 0x1234->0xABCD mid-frame -> the remainder of the frame still shows 1234; the next frame shows 1110111,0011111,1001110,0111101.
REQ-031 error=4'h7 -> from the next frame start, the digits show E, r, r, 7 (1001111,0000101,0000101,1110000); error=0 restores normal display at the following frame start.
REQ-032 blank=4'b0101, digits=0x8888 -> digits 2 and 0 show 0000000 and digits 3 and 1 show 1111111.
REQ-033 Macro defined, brightness=4 -> each slot has an low for exactly 4 of 16 cycles; brightness=15 -> 16/16; brightness=0 -> an stays all ones.
REQ-034 rst pulsed mid-slot -> seg=0 and an=1111 asynchronously, and the scan restarts at digit 3.
